// File: rtl/rom_burst_reader.sv
// rom_burst_reader: command-driven burst reader for a synchronous ROM.
// It issues one address per cycle and re-aligns the ROM data to a registered, flagged output stream.
module rom_burst_reader #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int LW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [1:0]    cmd_mode,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          dout_last,
  output logic          busy,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t          state;
  logic [LW-1:0]   remaining;
  logic [1:0]      mode;
  logic [RD_LAT-1:0] tag_v, tag_l;
  logic [RD_LAT:0] v_ext, l_ext;
  logic            issue, last_issue, tag_out;
  logic [AW-1:0]   next_addr;
  assign cmd_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign issue      = state == ISSUE;
  assign last_issue = issue && remaining == '0;
  // The widened concatenation lets the tag pipe shift cleanly even when RD_LAT is 1.
  assign v_ext      = {tag_v, issue};
  assign l_ext      = {tag_l, last_issue};
  assign tag_out    = tag_v[RD_LAT-1];
  assign next_addr  = mode == 2'b01 ? rom_addr - AW'(1) :
                      mode == 2'b10 ? rom_addr : rom_addr + AW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      mode       <= '0;
      rom_addr   <= '0;
      tag_v      <= '0;
      tag_l      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      tag_v      <= v_ext[RD_LAT-1:0];
      tag_l      <= l_ext[RD_LAT-1:0];
      dout_valid <= tag_out;
      dout_last  <= tag_out && tag_l[RD_LAT-1];
      if (tag_out) dout <= rom_data;
      case (state)
        IDLE:
          if (cmd_valid) begin
            if (cmd_len == '0) err <= 1'b1;
            else begin
              rom_addr  <= cmd_addr;
              remaining <= cmd_len - LW'(1);
              mode      <= cmd_mode;
              state     <= ISSUE;
            end
          end
        ISSUE:
          if (remaining != '0) begin
            rom_addr  <= next_addr;
            remaining <= remaining - LW'(1);
          end else state <= DRAIN;
        DRAIN:
          if (dout_last && tag_v == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed and random bursts against a cycle-timed word-list model.
module tb_rom_burst_reader;
  localparam int AW = 5, DW = 8, LW = 6, LAT = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0, rom_addr;
  logic [LW-1:0] cmd_len = '0;
  logic [1:0] cmd_mode = '0;
  logic [DW-1:0] rom_data, dout;
  logic dout_valid, dout_last, busy, err;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rom_pipe [LAT];
  int checks = 0, errors = 0;
  logic [AW-1:0] prev_addr = '0;

  rom_burst_reader #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mode(cmd_mode),
    .rom_addr(rom_addr), .rom_data(rom_data), .dout(dout),
    .dout_valid(dout_valid), .dout_last(dout_last), .busy(busy), .err(err));

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_pipe[0] <= mem[rom_addr];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_at(input int a, input int m, input int i);
    int r;
    r = m == 1 ? a - i : m == 2 ? a : a + i;
    return AW'((r % (2**AW) + 2**AW) % (2**AW));
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_timeout", 32'(guard < 200), 1);
  endtask

  task automatic run_cmd(input int a, input int len, input int m);
    int first, last;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_addr = AW'(a);
    cmd_len = LW'(len);
    cmd_mode = 2'(m);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = AW'($urandom);
    cmd_len = LW'($urandom);
    cmd_mode = 2'($urandom);
    if (len == 0) begin
      @(negedge clk);
      chk("zero_err", 32'(err), 1);
      chk("zero_valid", 32'(dout_valid), 0);
      chk("zero_ready", 32'(cmd_ready), 1);
      chk("zero_addr", 32'(rom_addr), 32'(prev_addr));
      @(negedge clk);
      chk("zero_err_drop", 32'(err), 0);
      return;
    end
    first = LAT + 2;
    last = LAT + 1 + len;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      chk("addr", 32'(rom_addr), 32'(addr_at(a, m, (k <= len ? k : len) - 1)));
      chk("valid", 32'(dout_valid), 32'(k >= first && k <= last));
      chk("last", 32'(dout_last), 32'(k == last));
      chk("ready", 32'(cmd_ready), 32'(k > last));
      chk("busy", 32'(busy), 32'(k <= last));
      chk("err", 32'(err), 0);
      if (k >= first && k <= last) chk("data", 32'(dout), 32'(mem[addr_at(a, m, k - first)]));
      // Commands offered while busy must be ignored.
      cmd_valid = k <= LAT + len ? 1'($urandom) : 1'b0;
    end
    prev_addr = addr_at(a, m, len - 1);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i + 'h10);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_outs", {dout, dout_valid, dout_last, busy, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(3, 8, 0);
    run_cmd(30, 4, 0);
    run_cmd(1, 3, 1);
    run_cmd(10, 5, 2);
    run_cmd(7, 0, 0);
    run_cmd(0, 2, 0);
    run_cmd(4, 2, 3);
    run_cmd(0, 1, 1);
    run_cmd(20, 63, 0);
    run_cmd(2, 40, 1);
    for (int n = 0; n < 12; n++)
      run_cmd($urandom_range(0, 31), $urandom_range(0, 20), $urandom_range(0, 3));
    wait_ready();
    cmd_valid = 1'b1;
    cmd_addr = 5;
    cmd_len = 8;
    cmd_mode = 0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("pre_rst_valid", 32'(dout_valid), 1);
    chk("pre_rst_data", 32'(dout), 32'(mem[7]));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_outs", {dout, dout_valid, dout_last, busy, err}, 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    prev_addr = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {dout_valid, dout_last, busy}, 0);
    end
    run_cmd(9, 6, 0);
    run_cmd($urandom_range(0, 31), $urandom_range(1, 63), $urandom_range(0, 3));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
